// File: rtl/mopshub_arb_pkg.sv
// Shared types and constants for the MOPSHUB receive/transmit schedulers.
//   N_BUS, BUS_W    : bus count and bus index width
//   TIMEOUT_W       : width of the per-transfer watchdog counter
//   rec_arb_state_t : receive arbiter state encoding
//   bus_mask()      : keeps bits 0..n of a per-bus vector
package mopshub_arb_pkg;

    localparam int unsigned N_BUS     = 32;
    localparam int unsigned BUS_W     = 5;
    localparam int unsigned TIMEOUT_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } rec_arb_state_t;

    // Enable mask for buses 0..n (inclusive).
    function automatic logic [N_BUS-1:0] bus_mask(input logic [BUS_W-1:0] n);
        logic [N_BUS-1:0] m;
        m = '0;
        for (int i = 0; i < N_BUS; i++) begin
            m[i] = (BUS_W'(i) <= n);
        end
        return m;
    endfunction

endpackage

// File: rtl/can_rec_arbiter_32bus_rr_find_next.sv
// Round-robin next-request finder (combinational).
// Searches req starting at last_grant+1, wrapping from n_buses back to 0;
// the search starts at 0 when last_grant >= n_buses.
//   req        : per-bus request vector
//   last_grant : index of the previously served bus
//   n_buses    : highest enabled bus index, inclusive
//   winner     : index of the first request found
//   found      : a request exists inside the window 0..n_buses
module rr_find_next
    import mopshub_arb_pkg::*;
(
    input  logic [N_BUS-1:0] req,
    input  logic [BUS_W-1:0] last_grant,
    input  logic [BUS_W-1:0] n_buses,
    output logic [BUS_W-1:0] winner,
    output logic             found
);

    localparam int unsigned IDX_W = BUS_W + 1;

    logic [IDX_W-1:0] first;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] limit;

    // Walk k = 0..n_buses from the start point; a single wrap is enough
    // because start + k never exceeds 2*n_buses.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        limit  = {1'b0, n_buses};
        first  = (last_grant >= n_buses) ? '0 : ({1'b0, last_grant} + IDX_W'(1));
        for (int k = 0; k < N_BUS; k++) begin
            idx = first + IDX_W'(k);
            if (idx > limit) begin
                idx = idx - (limit + IDX_W'(1));
            end
            if (!found && (IDX_W'(k) <= limit) && req[idx[BUS_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[BUS_W-1:0];
            end
        end
    end

endmodule

// File: rtl/can_rec_arbiter_32bus.sv
// Round-robin scheduler sharing the CAN-to-uplink receive path among 32 buses.
// Optional watchdog abort of a stuck transfer: define REC_TIMEOUT_EN.
//   clk            : system clock
//   rst            : asynchronous reset, active low
//   n_buses        : highest enabled bus index, inclusive
//   irq_can_rec    : per-bus pending-frame level request
//   busy_uplink    : uplink transmitter busy, blocks new grants
//   end_rec        : end-of-transfer pulse from the selected core
//   can_rec_select : granted bus index
//   start_rec      : one-cycle transfer start strobe
//   rec_active     : high from START through WAIT
//   rec_frame_cnt  : completed transfer count (wraps)
//   timeout_err    : one-cycle pulse on an aborted transfer
module can_rec_arbiter_32bus
    import mopshub_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       n_buses,
    input  logic [31:0]      irq_can_rec,
    input  logic             busy_uplink,
    input  logic             end_rec,
    output logic [4:0]       can_rec_select,
    output logic             start_rec,
    output logic             rec_active,
    output logic [15:0]      rec_frame_cnt,
    output logic             timeout_err
);

    rec_arb_state_t   state;
    rec_arb_state_t   state_nxt;

    logic [N_BUS-1:0] eligible_c;
    logic [N_BUS-1:0] req_q;
    logic [BUS_W-1:0] n_q;
    logic [BUS_W-1:0] last_grant;
    logic [BUS_W-1:0] winner_c;
    logic             found_c;
    logic             timeout_hit_c;

    assign eligible_c = irq_can_rec & bus_mask(n_buses);

    rr_find_next u_find (
        .req        (req_q),
        .last_grant (last_grant),
        .n_buses    (n_q),
        .winner     (winner_c),
        .found      (found_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if ((|eligible_c) && !busy_uplink) state_nxt = ARB;
            ARB:   state_nxt = found_c ? START : IDLE;
            START: state_nxt = WAIT;
            WAIT:  if (end_rec || timeout_hit_c) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, grant register, strobes and frame counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q          <= '0;
            n_q            <= '0;
            last_grant     <= BUS_W'(N_BUS - 1);
            can_rec_select <= '0;
            start_rec      <= 1'b0;
            rec_active     <= 1'b0;
            rec_frame_cnt  <= '0;
        end else begin
            start_rec  <= (state_nxt == START);
            rec_active <= (state_nxt == START) || (state_nxt == WAIT);
            if ((state == IDLE) && (state_nxt == ARB)) begin
                // n_buses is captured with the requests so a change only
                // affects the next arbitration round.
                req_q <= eligible_c;
                n_q   <= n_buses;
            end
            if ((state == ARB) && found_c) begin
                can_rec_select <= winner_c;
            end
            if (state == DONE) begin
                last_grant <= can_rec_select;
                if (!timeout_err) begin
                    rec_frame_cnt <= rec_frame_cnt + 16'd1;
                end
            end
        end
    end

`ifdef REC_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt;

    // Abort after TIMEOUT_CYCLES cycles spent in WAIT without end_rec.
    assign timeout_hit_c = (state == WAIT) && !end_rec &&
                           (to_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter and abort pulse; timeout_err is high during DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit_c;
            if (state == START) begin
                to_cnt <= '0;
            end else if (state == WAIT) begin
                to_cnt <= to_cnt + TIMEOUT_W'(1);
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout_hit_c      = 1'b0;
    assign timeout_err        = 1'b0;
`endif

endmodule

// File: doc/can_rec_arbiter_32bus.md
# can_rec_arbiter_32bus

Round-robin scheduler that shares the single CAN-to-uplink receive path of the 32-bus MOPSHUB among all CAN bus cores. It watches the per-bus receive interrupts and drives `can_rec_select`, so that exactly one bus at a time moves its 76-bit frame into `data_rec_uplink`. Each transfer is started with a one-cycle strobe and closed by the CAN core's end handshake. It sits between the 32 CAN receive cores and the elink uplink transmitter in `mopshub_top_32bus`.

## Interface
- `TIMEOUT_CYCLES`, default 4096: watchdog limit in clk cycles for one transfer. Used only when `REC_TIMEOUT_EN` is defined.
- `clk  in  1`: 40 MHz system clock.
- `rst  in  1`: asynchronous, active-low reset.
- `n_buses  in  5`: highest enabled bus index, inclusive. 31 means all buses are enabled.
- `irq_can_rec  in  32`: level request per bus. Bit i high means bus i holds a received frame. The bit stays high until the bus is served.
- `busy_uplink  in  1`: elink transmitter busy. No new grant is issued while this is high.
- `end_rec  in  1`: one-cycle pulse from the selected core when its frame is in `data_rec_uplink`.
- `can_rec_select  out  5`: index of the granted bus.
- `start_rec  out  1`: one-cycle strobe that starts the transfer on the selected bus.
- `rec_active  out  1`: high from START through WAIT.
- `rec_frame_cnt  out  16`: count of completed transfers. Wraps from 0xFFFF to 0.
- `timeout_err  out  1`: one-cycle pulse when a transfer is aborted. Tied to 0 without `REC_TIMEOUT_EN`.

## Operation
- States: IDLE, ARB, START, WAIT, DONE.
- Eligible request vector: `irq_can_rec & mask(n_buses)`. The mask keeps bits 0..n_buses only.
- IDLE:
  - Leave IDLE when the eligible vector is nonzero and `busy_uplink` is 0.
  - On that edge, latch the eligible vector into `req_q` and go to ARB.
- ARB (one cycle):
  - Winner is the first set bit of `req_q` searching `last_grant+1, +2, …`, wrapping from `n_buses` to 0.
  - If `last_grant >= n_buses`, the search starts at 0.
  - Register the winner into `can_rec_select`, then go to START.
- START (one cycle): `start_rec` = 1, `rec_active` = 1, then go to WAIT.
- WAIT:
  - Hold `can_rec_select`.
  - On `end_rec` = 1, go to DONE.
  - `irq_can_rec` changes and `busy_uplink` are ignored here.
- DONE (one cycle):
  - `last_grant` ← `can_rec_select`.
  - `rec_frame_cnt` += 1.
  - Go to IDLE.
- `end_rec` is ignored in every state except WAIT.
- A winner whose irq drops between latch and START is still started. The CAN core already holds the frame.
- A change of `n_buses` takes effect at the next IDLE→ARB latch. It never aborts an active transfer.
- `can_rec_select` holds its last value in IDLE. It is never left pointing at an out-of-range bus after a new grant.
- Reset mid-transfer returns everything to reset values immediately. The CAN core's frame stays pending and is re-served after reset.
- Reset values: state IDLE, `can_rec_select` 0, `start_rec` 0, `rec_active` 0, `rec_frame_cnt` 0, `timeout_err` 0, `last_grant` 31 (so the first search begins at bus 0).

## Timing
- IRQ sampled in IDLE at edge N: ARB in cycle N+1, `can_rec_select` valid from N+2, `start_rec` high in cycle N+2 only.
- `end_rec` at edge M in WAIT: DONE in M+1, IDLE in M+2. The earliest next `start_rec` is in M+4.
- Minimum grant period is 5 cycles per frame. With all 32 buses requesting, every bus is served once in 32 grants.
- `busy_uplink` sampled high in IDLE delays the grant cycle by cycle, with no state change.

## Configuration
- `REC_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to WAIT and counts up in WAIT.
  - When it reaches `TIMEOUT_CYCLES` with no `end_rec`, pulse `timeout_err` for one cycle, go to DONE, and set `last_grant` to the timed-out bus.
  - `rec_frame_cnt` is not incremented on a timeout.
- `REC_TIMEOUT_EN` undefined: no counter is built, WAIT waits indefinitely, and `timeout_err` = 0.

## Structure
- Package `mopshub_arb_pkg`:
  - `N_BUS` = 32, `BUS_W` = 5.
  - `rec_arb_state_t` enum (IDLE, ARB, START, WAIT, DONE).
  - `TIMEOUT_W` = 16.
- Sub-module `rr_find_next`: combinational. Inputs are the 32-bit request, `last_grant`, and `n_buses`. Outputs are the winner index and a `found` flag. It is reusable by a future transmit scheduler.

## Test plan
- Reset, `n_buses`=31, `irq_can_rec`=0x0000_0001, `end_rec` 3 cycles after `start_rec`: `can_rec_select`=0, one `start_rec` pulse, `rec_frame_cnt`=1.
- `irq_can_rec`=0xFFFF_FFFF held, `end_rec` returned 3 cycles after each start: grant order 0,1,…,31,0, and each `start_rec` is 7 cycles after the previous one.
- `n_buses`=7, `irq_can_rec`=0x0000_0F81: only buses 0 and 7 are granted, alternating 0,7,0. Bus 8 and above are never selected.
- `busy_uplink`=1 for 20 cycles with `irq_can_rec`=0x10: no `start_rec` until 2 cycles after `busy_uplink` falls. `can_rec_select` then becomes 4.
- `REC_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, `irq_can_rec`=0x6, no `end_rec`: `timeout_err` pulses, `rec_frame_cnt` stays 0, and the next grant is bus 2.
- `rst` asserted in WAIT: all outputs reach reset values with no clock edge needed. After release the pending bus is granted again.
